// File: rtl/fmr_health_tracker.sv
// Health manager for a 5MR voter: per-replica saturating fault counters, retirement
// of persistently disagreeing replicas down to MIN_ACTIVE, and a sticky alarm.
module fmr_health_tracker #(
  parameter int CNT_W      = 4,
  parameter int FAIL_TH    = 4,
  parameter int MIN_ACTIVE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [4:0] disagree,
  input  logic       clear_fault,
  output logic [4:0] g,
  output logic [2:0] n_active,
  output logic [1:0] state,
  output logic       fail_event,
  output logic [2:0] fail_id,
  output logic       alarm
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    CRITICAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TH    = CNT_W'(FAIL_TH);
  localparam logic [2:0]       MIN_N = 3'(MIN_ACTIVE);

  logic [CNT_W-1:0] cnt     [5];
  logic [CNT_W-1:0] cnt_nxt [5];
  logic [4:0]       g_nxt;
  logic [2:0]       n_nxt;
  state_t           state_q, state_nxt;
  logic             fail_event_nxt;
  logic [2:0]       fail_id_nxt;
  logic             alarm_nxt;
  logic             found;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (c >= TH) ? TH : c + CNT_W'(1);
    else    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] sum;
    sum = '0;
    for (int i = 0; i < 5; i++) sum = sum + 3'(v[i]);
    return sum;
  endfunction

  function automatic state_t state_of(input logic [2:0] n);
    if (n == 3'd5)      return NORMAL;
    else if (n > MIN_N) return DEGRADED;
    else                return CRITICAL;
  endfunction

  always_comb begin
    cnt_nxt        = cnt;
    g_nxt          = g;
    fail_event_nxt = 1'b0;
    fail_id_nxt    = fail_id;
    alarm_nxt      = alarm;
    found          = 1'b0;
    if (clear_fault) begin
      for (int i = 0; i < 5; i++) cnt_nxt[i] = '0;
      g_nxt       = 5'b11111;
      fail_id_nxt = 3'd0;
      alarm_nxt   = 1'b0;
    end else if (valid_in) begin
      for (int i = 0; i < 5; i++)
        cnt_nxt[i] = g[i] ? sat_step(cnt[i], disagree[i]) : '0;
      // Lowest-index candidate wins; the rest stay saturated for later cycles.
      for (int i = 0; i < 5; i++) begin
        if (!found && g[i] && (cnt_nxt[i] == TH)) begin
          found = 1'b1;
          if (n_active > MIN_N) begin
            g_nxt[i]       = 1'b0;
            cnt_nxt[i]     = '0;
            fail_event_nxt = 1'b1;
            fail_id_nxt    = 3'(i);
          end else begin
            alarm_nxt = 1'b1;
          end
        end
      end
    end
    n_nxt     = popcount5(g_nxt);
    state_nxt = state_of(n_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
      g          <= 5'b11111;
      n_active   <= 3'd5;
      state_q    <= NORMAL;
      fail_event <= 1'b0;
      fail_id    <= 3'd0;
      alarm      <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      g          <= g_nxt;
      n_active   <= n_nxt;
      state_q    <= state_nxt;
      fail_event <= fail_event_nxt;
      fail_id    <= fail_id_nxt;
      alarm      <= alarm_nxt;
    end
  end

  assign state = state_q;

endmodule
